// File: rtl/seq_addsub_pkg.sv
// seq_addsub_pkg: shared types and elaboration helpers for the chunked add/subtract unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of CHUNK-wide slices making up one WIDTH-wide operand.
  function automatic int nchunk_f(input int width, input int chunk);
    return width / chunk;
  endfunction

  // True when the width/chunk pair describes a whole number of slices.
  function automatic bit cfg_ok_f(input int width, input int chunk);
    return (chunk > 0) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/seq_addsub_chunk_adder.sv
// chunk_adder: CHUNK-bit ripple slice adder with carry in/out.
// Latency: purely combinational.
// Backpressure: none.
module chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             c_in,
  output logic [CHUNK-1:0] f,
  output logic             c_out
);

  assign {c_out, f} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, c_in};

endmodule

// File: rtl/seq_addsub.sv
// seq_addsub: WIDTH-bit add/subtract computed CHUNK bits per cycle through one slice adder.
// Latency: ready pulses NCHUNK+1 cycles after the accepting edge; one op per NCHUNK+2 cycles.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped.
module seq_addsub
  import seq_addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             busy,
  output logic             ready
);

  localparam int NCHUNK = nchunk_f(WIDTH, CHUNK);
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  if (!cfg_ok_f(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("seq_addsub: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  op_a_q, op_a_d;
  logic [WIDTH-1:0]  op_b_q, op_b_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              c_q, c_d;
  logic              carry_q, carry_d;
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;

  logic [CHUNK-1:0]  a_sl, b_sl, f;
  logic              co;
  logic              accept;
  logic              last;

  assign accept = (state_q == IDLE) && start;
  assign last   = (state_q == RUN) && (idx_q == LAST_IDX);

  // Current slice of each operand, selected by the chunk index.
  assign a_sl = op_a_q[int'(idx_q)*CHUNK +: CHUNK];
  assign b_sl = op_b_q[int'(idx_q)*CHUNK +: CHUNK];

  chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .a     (a_sl),
    .b     (b_sl),
    .c_in  (c_q),
    .f     (f),
    .c_out (co)
  );

  // Next-state logic: one RUN pass of NCHUNK cycles, then a single DONE cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (idx_q == LAST_IDX) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state: capture on accept, one slice per RUN cycle, flags on the last slice.
  always_comb begin
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    res_d   = res_q;
    c_d     = c_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    if (accept) begin
      // Subtraction is folded into the add: a + ~b with the carry register seeded to 1.
      op_a_d = a;
      op_b_d = sub ? ~b : b;
      c_d    = sub;
      idx_d  = '0;
      res_d  = '0;
    end else if (state_q == RUN) begin
      res_d[int'(idx_q)*CHUNK +: CHUNK] = f;
      c_d   = co;
      idx_d = last ? '0 : idx_q + 1'b1;
      if (last) begin
        carry_d = co;
        // Signed overflow on the effective operands: like signs in, different sign out.
        ovf_d   = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) && (f[CHUNK-1] != op_a_q[WIDTH-1]);
        zero_d  = (res_d == '0);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and flag registers; an in-flight operation is abandoned on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_q  <= '0;
      op_b_q  <= '0;
      res_q   <= '0;
      c_q     <= 1'b0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      res_q   <= res_d;
      c_q     <= c_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign res      = res_q;
  assign carry    = carry_q;
  assign overflow = ovf_q;
  assign zero     = zero_q;
  assign busy     = (state_q != IDLE);
  assign ready    = (state_q == DONE);

endmodule

// File: tb/tb_seq_addsub.sv
// tb_seq_addsub: scoreboard bench for seq_addsub at four width/chunk configurations.
// Latency: checks ready arrives exactly NCHUNK+1 cycles after the accepting edge.
// Backpressure: exercises start during RUN/DONE and start held high.
module tb_seq_addsub;

  typedef struct {
    int          sel;
    logic [31:0] res;
    logic        c;
    logic        o;
    logic        z;
    longint      cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [3:0]  start_v;
  logic        sub;
  logic [31:0] a, b;
  logic [31:0] res0;
  logic [23:0] res1;
  logic [15:0] res2;
  logic [7:0]  res3;
  logic [3:0]  carry_v, ovf_v, zero_v, busy_v, ready_v;

  exp_t   sbq[$];
  exp_t   mon_e;
  longint cyc;
  int     n_vec;
  int     n_err;

  seq_addsub #(.WIDTH(32), .CHUNK(8)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub), .a(a), .b(b),
    .res(res0), .carry(carry_v[0]), .overflow(ovf_v[0]), .zero(zero_v[0]),
    .busy(busy_v[0]), .ready(ready_v[0]));

  seq_addsub #(.WIDTH(24), .CHUNK(8)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub), .a(a[23:0]), .b(b[23:0]),
    .res(res1), .carry(carry_v[1]), .overflow(ovf_v[1]), .zero(zero_v[1]),
    .busy(busy_v[1]), .ready(ready_v[1]));

  seq_addsub #(.WIDTH(16), .CHUNK(16)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .sub(sub), .a(a[15:0]), .b(b[15:0]),
    .res(res2), .carry(carry_v[2]), .overflow(ovf_v[2]), .zero(zero_v[2]),
    .busy(busy_v[2]), .ready(ready_v[2]));

  seq_addsub #(.WIDTH(8), .CHUNK(1)) u_dut3 (
    .clk(clk), .rst(rst), .start(start_v[3]), .sub(sub), .a(a[7:0]), .b(b[7:0]),
    .res(res3), .carry(carry_v[3]), .overflow(ovf_v[3]), .zero(zero_v[3]),
    .busy(busy_v[3]), .ready(ready_v[3]));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int wid(input int sel);
    case (sel)
      0: return 32;
      1: return 24;
      2: return 16;
      default: return 8;
    endcase
  endfunction

  function automatic int nch(input int sel);
    case (sel)
      0: return 4;
      1: return 3;
      2: return 1;
      default: return 8;
    endcase
  endfunction

  function automatic logic [31:0] dres(input int sel);
    case (sel)
      0: return res0;
      1: return {8'h0, res1};
      2: return {16'h0, res2};
      default: return {24'h0, res3};
    endcase
  endfunction

  // Full-width reference: modular sum with an explicit extra carry bit.
  function automatic exp_t model(input int sel, input logic [31:0] av, input logic [31:0] bv,
                                 input logic s, input longint c);
    exp_t        e;
    int          w;
    logic [33:0] mask, ea, eb, sum;
    w    = wid(sel);
    mask = (34'd1 << w) - 34'd1;
    ea   = {2'b00, av} & mask;
    eb   = {2'b00, (s ? ~bv : bv)} & mask;
    sum  = ea + eb + {33'd0, s};
    e.sel = sel;
    e.res = 32'(sum & mask);
    e.c   = sum[w];
    e.o   = (ea[w-1] == eb[w-1]) && (sum[w-1] != ea[w-1]);
    e.z   = ((sum & mask) == 34'd0);
    e.cyc = c;
    return e;
  endfunction

  // Called at a negedge in IDLE: one-cycle start pulse, expected result queued.
  task automatic issue(input int sel, input logic [31:0] av, input logic [31:0] bv, input logic s);
    a = av;
    b = bv;
    sub = s;
    start_v[sel] = 1'b1;
    sbq.push_back(model(sel, av, bv, s, cyc + 1 + nch(sel)));
    @(negedge clk);
    start_v[sel] = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (sbq.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (sbq.size() != 0) begin
      chk("done_timeout", 64'(sbq.size()), 64'd0);
      sbq.delete();
    end
    @(negedge clk);
  endtask

  task automatic op(input int sel, input logic [31:0] av, input logic [31:0] bv, input logic s);
    issue(sel, av, bv, s);
    wait_done();
  endtask

  task automatic wait_cyc(input longint target);
    int k;
    k = 0;
    while (cyc != target && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (cyc != target) chk("cyc_timeout", 64'(cyc), 64'(target));
  endtask

  // Scoreboard: every ready pops one expectation and checks result, flags and latency.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ready_v[i]) begin
        if (sbq.size() == 0) begin
          chk("spurious_ready", 64'(i), 64'hFF);
        end else begin
          mon_e = sbq.pop_front();
          chk("ready_dut", 64'(i), 64'(mon_e.sel));
          chk("res", {32'h0, dres(i)}, {32'h0, mon_e.res});
          chk("carry", {63'h0, carry_v[i]}, {63'h0, mon_e.c});
          chk("overflow", {63'h0, ovf_v[i]}, {63'h0, mon_e.o});
          chk("zero", {63'h0, zero_v[i]}, {63'h0, mon_e.z});
          chk("latency", 64'(cyc), 64'(mon_e.cyc));
          chk("busy_at_ready", {63'h0, busy_v[i]}, 64'd1);
        end
      end
    end
  end

  initial begin
    longint c0;
    clk = 1'b0;
    rst = 1'b1;
    start_v = '0;
    sub = 1'b0;
    a = '0;
    b = '0;
    cyc = 0;
    n_vec = 0;
    n_err = 0;

    #2;
    chk("rst_res0", {32'h0, res0}, 64'd0);
    chk("rst_flags", {44'h0, carry_v, ovf_v, zero_v, busy_v, ready_v}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Directed 32/8 cases.
    op(0, 32'h0000_00FF, 32'h0000_0001, 1'b0);
    op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    op(0, 32'd5, 32'd7, 1'b1);
    op(0, 32'd7, 32'd7, 1'b1);
    op(0, 32'h8000_0000, 32'h0000_0001, 1'b1);

    // start pulsed during RUN and DONE must not disturb the first result.
    issue(0, 32'h0000_0100, 32'h0000_0023, 1'b0);
    c0 = cyc;
    @(negedge clk);
    a = 32'hDEAD_BEEF;
    b = 32'h1111_1111;
    sub = 1'b1;
    start_v[0] = 1'b1;
    chk("busy_run", {63'h0, busy_v[0]}, 64'd1);
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_cyc(c0 + 4);
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (10) @(negedge clk);
    chk("ignored_drained", 64'(sbq.size()), 64'd0);
    chk("idle_busy", {63'h0, busy_v[0]}, 64'd0);

    // start held high: one completion every NCHUNK+2 = 6 cycles.
    c0 = cyc;
    a = 32'h0001_0000;
    b = 32'h0000_FFFF;
    sub = 1'b0;
    for (int k = 0; k < 3; k++) sbq.push_back(model(0, a, b, 1'b0, c0 + 5 + 6 * k));
    start_v[0] = 1'b1;
    wait_cyc(c0 + 17);
    start_v[0] = 1'b0;
    wait_done();

    // Reset during RUN with idx 2: partial result visible, then everything clears at once.
    issue(0, 32'h0000_1234, 32'h0000_0001, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("partial_res", {32'h0, res0}, 64'h1235);
    rst = 1'b1;
    #1;
    chk("midrst_res0", {32'h0, res0}, 64'd0);
    chk("midrst_flags", {44'h0, carry_v, ovf_v, zero_v, busy_v, ready_v}, 64'd0);
    sbq.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    op(0, 32'd3, 32'd4, 1'b0);

    // Other configurations: boundary cases.
    op(1, 32'h00FF_FFFF, 32'h0000_0001, 1'b0);
    op(1, 32'h007F_FFFF, 32'h0000_0001, 1'b0);
    op(2, 32'h0000_7FFF, 32'h0000_0001, 1'b0);
    op(2, 32'h0000_0009, 32'h0000_0009, 1'b1);
    op(3, 32'h0000_0080, 32'h0000_0001, 1'b1);
    op(3, 32'h0000_000F, 32'h0000_0001, 1'b0);

    // Random operands across all configurations.
    for (int k = 0; k < 40; k++) begin
      op(int'($urandom_range(0, 3)), $urandom, $urandom, 1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    chk("sb_drain", 64'(sbq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_addsub.md
# seq_addsub

Multi-cycle, parametrised add/subtract unit that processes a WIDTH-bit operation CHUNK bits per cycle through one narrow chunk adder, rippling the carry through a register between cycles. It replaces the fixed 32-bit/8-bit sequential adder in the verilog_sim datapath. It adds a subtract mode, configurable width and chunk size, a busy output, and carry, signed-overflow and zero flags. It trades latency for adder area where a full-width adder is not warranted.

## Interface
- WIDTH, 32: operand and result width; must be a multiple of CHUNK.
- CHUNK, 8: bits processed per cycle; NCHUNK = WIDTH/CHUNK (1..WIDTH).
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- sub  in  1  0 = a+b, 1 = a-b; captured with operands.
- a, b  in  WIDTH  operands; captured on the accepting edge.
- res  out  WIDTH  result; held from DONE until the next accepted start.
- carry  out  1  carry out of the MSB chunk (for sub: 1 = no borrow).
- overflow  out  1  two's-complement overflow.
- zero  out  1  res == 0.
- busy  out  1  high in RUN and DONE.
- ready  out  1  one-cycle pulse in DONE; the flags are valid from then on.

## Operation
- States are IDLE, RUN and DONE. IDLE→RUN on start; RUN→DONE after NCHUNK cycles; DONE→IDLE unconditionally.
- **Accept (IDLE & start):**
  - Capture op_a=a and op_b = sub ? ~b : b.
  - Set the carry register to sub and the chunk index idx to 0.
  - Clear res.
- **RUN, each cycle:**
  - Compute f, co = op_a[idx] + op_b[idx] + c_reg, where op_x[idx] is the CHUNK-bit slice at idx*CHUNK.
  - Write f into res slice idx and co into c_reg, then increment idx.
- **RUN, last cycle (idx == NCHUNK-1):** also latch the flags:
  - carry = co.
  - overflow = (op_a MSB == op_b MSB) && (f MSB != op_a MSB).
  - zero from the completed res.
- **DONE:** assert ready; the outputs are stable.
- **start outside IDLE:** ignored. Inputs are not re-captured and the in-flight operation is unaffected.
- **start held continuously:** a new operation is accepted in every IDLE cycle, so one operation completes per NCHUNK+2 cycles.
- **Arithmetic:** modulo 2^WIDTH. Subtraction is a + ~b + 1. Overflow uses the signed interpretation of the effective operands.
- **NCHUNK = 1:** RUN lasts one cycle; otherwise the behaviour is identical.

## Timing
- **Reset:** while rst is high, every register clears asynchronously. State = IDLE; res, carry, overflow, zero, busy, ready and idx are 0. zero reads 0 until the first DONE.
- **Reset mid-operation:** the operation is abandoned. Outputs go to their reset values immediately; the first start after deassertion is accepted normally.
- **Latency:** with start sampled high at the edge ending cycle T:
  - busy is high from T+1.
  - ready is high in cycle T+NCHUNK+1; busy falls after that cycle.
  - Example: WIDTH=32, CHUNK=8 gives ready in T+5.
- **Partial results:** res chunks update progressively during RUN, so res is valid only from DONE.
- **Combinational paths:** none from inputs to outputs; all outputs are registered.

## Structure
- **Package seq_addsub_pkg:**
  - State enum typedef: IDLE, RUN, DONE.
  - A function returning NCHUNK, plus an elaboration-time check that WIDTH % CHUNK == 0.
- **Sub-module chunk_adder #(CHUNK):** ports a, b, c_in; outputs f, c_out. Purely combinational; the one instance lives in the datapath.
- **Top level:** FSM, index counter ($clog2(NCHUNK) bits, minimum 1), operand/result registers and flag logic. Slice select and write-back use indexed part-selects, not per-chunk muxes.

## Test plan
- **Add with cross-chunk carry:** 0x0000_00FF + 0x0000_0001 → res 0x0000_0100, carry 0, overflow 0, zero 0, ready in T+5.
- **Signed overflow:** 0x7FFF_FFFF + 1 → 0x8000_0000, overflow 1, carry 0. 0xFFFF_FFFF + 1 → 0, carry 1, zero 1, overflow 0.
- **Subtract:**
  - 5 - 7 → 0xFFFF_FFFE, carry 0, overflow 0.
  - 7 - 7 → 0, carry 1, zero 1.
  - 0x8000_0000 - 1 → 0x7FFF_FFFF, overflow 1.
- **Start ignored during RUN:** pulse start with different a/b/sub during RUN and DONE → the first result is unchanged and no second ready appears. Holding start high → ready every 6 cycles.
- **Reset mid-operation:** assert rst during RUN idx 2 → all outputs 0 and busy 0 without a clock edge. After release, 3 + 4 → 7 with normal latency.
- **Parameter sweep:**
  - WIDTH=24, CHUNK=8: ready in T+4.
  - WIDTH=16, CHUNK=16: ready in T+2.
  - WIDTH=8, CHUNK=1: ready in T+9.
  - Random a/b/sub checked against a reference model.
